// File: rtl/status_reg_bank.sv
// Addressable status register bank: registered read port, sticky W1C error latches,
// saturating per-error edge counters, coherent two-word timestamp read and masked irq.
module status_reg_bank #(
  parameter int NUM_CHAN = 5,
  parameter int NUM_ERR  = 8,
  parameter int BURST_W  = 23,
  parameter int TS_W     = 44,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [23:0]                  fw_version,
  input  logic [NUM_ERR-1:0]           err_in,
  input  logic [TS_W-1:0]              trig_timestamp,
  input  logic [NUM_CHAN*BURST_W-1:0]  stored_bursts,
  input  logic                         rd_en,
  input  logic [7:0]                   rd_addr,
  output logic [31:0]                  rd_data,
  output logic                         rd_valid,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_addr,
  input  logic [31:0]                  wr_data,
  output logic                         irq
);

  localparam int SHADOW_W = TS_W - 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_ERR-1:0]  sticky;
  logic [NUM_ERR-1:0]  mask;
  logic [NUM_ERR-1:0]  err_prev;
  logic [NUM_ERR-1:0]  err_rise;
  logic [NUM_ERR-1:0]  sticky_clr;
  logic [SHADOW_W-1:0] ts_shadow;
  logic [CNT_W-1:0]    err_cnt [NUM_ERR];
  logic [31:0]         rd_mux;
  logic                wr_sticky;
  logic                wr_mask;
  logic                unused_wr_bits;

  assign err_rise   = err_in & ~err_prev;
  assign wr_sticky  = wr_en && (wr_addr == 8'h02);
  assign wr_mask    = wr_en && (wr_addr == 8'h05);
  assign sticky_clr = wr_sticky ? wr_data[NUM_ERR-1:0] : {NUM_ERR{1'b0}};
  assign unused_wr_bits = ^wr_data[31:NUM_ERR];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      8'h00:   rd_mux = {8'd0, fw_version};
      8'h01:   rd_mux = 32'(err_in);
      8'h02:   rd_mux = 32'(sticky);
      8'h03:   rd_mux = trig_timestamp[31:0];
      8'h04:   rd_mux = 32'(ts_shadow);
      8'h05:   rd_mux = 32'(mask);
      default: rd_mux = '0;
    endcase
    for (int i = 0; i < NUM_ERR; i++)
      if (rd_addr == 8'(8 + i)) rd_mux = 32'(err_cnt[i]);
    for (int c = 0; c < NUM_CHAN; c++)
      if (rd_addr == 8'(16 + c)) rd_mux = 32'(stored_bursts[c*BURST_W +: BURST_W]);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      irq       <= 1'b0;
      sticky    <= '0;
      mask      <= '0;
      err_prev  <= '0;
      ts_shadow <= '0;
    end else begin
      rd_valid <= rd_en;
      // The mux reads current state, so a same-cycle write is seen only by later reads.
      if (rd_en) rd_data <= rd_mux;
      if (rd_en && (rd_addr == 8'h03)) ts_shadow <= trig_timestamp[TS_W-1:32];
      sticky   <= (sticky & ~sticky_clr) | err_in;
      if (wr_mask) mask <= wr_data[NUM_ERR-1:0];
      err_prev <= err_in;
      irq      <= |(sticky & mask);
    end
  end

  // NOTE: the counter array is a set of flops, not a RAM, so every entry is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ERR; i++) err_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ERR; i++) begin
        if (wr_en && (wr_addr == 8'(8 + i)))
          err_cnt[i] <= CNT_W'(err_rise[i]);
        else if (err_rise[i] && (err_cnt[i] != CNT_MAX))
          err_cnt[i] <= err_cnt[i] + CNT_W'(1);
      end
    end
  end

endmodule
